dual_ram_clr: RTL

DUAL_RAM_CLR -- requirements
Module: dual_ram_clr

---
 rtl/dual_ram_clr_pkg.sv | 19 +
 rtl/ram_clr_seq.sv | 87 ++++++++
 rtl/dual_ram_clr.sv | 91 +++++++++
 3 files changed

// File: rtl/dual_ram_clr_pkg.sv
// ============================================================================
// Module  : dual_ram_clr_pkg
// Purpose : Shared types for the clearable dual-read RAM.
//           Holds the sequencer state encoding used by ram_clr_seq.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dual_ram_clr_pkg;

  // IDLE: normal read/write traffic. CLEAR: memory is being zeroed.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage : dual_ram_clr_pkg

`default_nettype wire

// File: rtl/ram_clr_seq.sv
// ============================================================================
// Module  : ram_clr_seq
// Purpose : Clear sequencer. Walks a counter over every address while in
//           CLEAR and decodes the status pulses.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           clr           - start / restart a clear
//           we            - user write request (only used for we_drop)
//           busy          - high exactly while in CLEAR
//           done          - pulse on the final clear write
//           we_drop       - pulse when a user write is rejected
//           clr_addr      - address being zeroed this cycle
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_clr_seq
  import dual_ram_clr_pkg::*;
#(
  parameter int ADDR_SIZE = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 we,
  output logic                 busy,
  output logic                 done,
  output logic                 we_drop,
  output logic [ADDR_SIZE-1:0] clr_addr
);

  // DEPTH-1 is all ones for a power-of-two depth.
  localparam logic [ADDR_SIZE-1:0] LAST = '1;

  state_t               state, state_nxt;
  logic [ADDR_SIZE-1:0] cnt, cnt_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (clr) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        if (clr) begin
          cnt_nxt = '0;                 // restart, no completion
        end else if (cnt == LAST) begin
          state_nxt = ST_IDLE;          // counter never wraps inside CLEAR
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ADDR_SIZE'(1);
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode
  always_comb begin
    busy     = (state == ST_CLEAR);
    // A restart or a reset on the last word means the clear is not complete.
    done     = busy && (cnt == LAST) && !clr && !rst;
    we_drop  = we && (busy || clr || rst);
    clr_addr = cnt;
  end

endmodule : ram_clr_seq

`default_nettype wire

// File: rtl/dual_ram_clr.sv
// ============================================================================
// Module  : dual_ram_clr
// Purpose : 2**ADDR_SIZE x DATA_SIZE RAM with one write / two combinational
//           read ports, optional write-to-read forwarding and a whole-array
//           clear sequence.
// Ports   : CLK, RST      - clock, synchronous active-high reset
//           ADRX          - write address and port-X read address
//           ADRY          - port-Y read address
//           DIN, WE       - write data / write request
//           CLR           - start (or restart) a full clear
//           DX_OUT,DY_OUT - read data for ADRX / ADRY
//           BUSY          - clear in progress
//           DONE          - pulse on the last clear write
//           WE_DROP       - pulse when a write is rejected
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dual_ram_clr #(
  parameter int ADDR_SIZE = 5,
  parameter int DATA_SIZE = 8,
  parameter int BYPASS    = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [ADDR_SIZE-1:0] ADRX,
  input  logic [ADDR_SIZE-1:0] ADRY,
  input  logic [DATA_SIZE-1:0] DIN,
  input  logic                 WE,
  input  logic                 CLR,
  output logic [DATA_SIZE-1:0] DX_OUT,
  output logic [DATA_SIZE-1:0] DY_OUT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 WE_DROP
);

  localparam int DEPTH = 2 ** ADDR_SIZE;

  // Zero-initialised so simulation starts from a known array.
  logic [DATA_SIZE-1:0] mem [DEPTH] = '{default: '0};

  logic [ADDR_SIZE-1:0] clr_addr;
  logic                 busy;
  logic                 user_wr;
  logic                 fwd;

  ram_clr_seq #(
    .ADDR_SIZE (ADDR_SIZE)
  ) u_seq (
    .clk      (CLK),
    .rst      (RST),
    .clr      (CLR),
    .we       (WE),
    .busy     (busy),
    .done     (DONE),
    .we_drop  (WE_DROP),
    .clr_addr (clr_addr)
  );

  assign BUSY    = busy;
  // A user write is accepted only in IDLE with no clear request and no reset.
  assign user_wr = WE && !CLR && !RST && !busy;
  assign fwd     = (BYPASS != 0) && user_wr;

  // Single write port shared between the clear walker and user writes.
  always @(posedge CLK) begin
    if (busy) begin
      mem[clr_addr] <= '0;
    end else if (user_wr) begin
      mem[ADRX] <= DIN;
    end
  end

  always_comb begin
    DX_OUT = mem[ADRX];
    DY_OUT = mem[ADRY];
    if (RST || busy) begin
      DX_OUT = '0;
      DY_OUT = '0;
    end else if (fwd) begin
      DX_OUT = DIN;
      if (ADRY == ADRX) begin
        DY_OUT = DIN;
      end
    end
  end

endmodule : dual_ram_clr

`default_nettype wire
